// File: rtl/pll_lock_sequencer.sv
// Purpose: synchronise PLL lock, sequence the core reset, generate a divided clock enable and count lock losses.
// Latency: reset releases SYNC_STAGES+1+HOLD_CYCLES edges after lock rises; RUN exits LOSS_FILTER edges after lk falls.
// Backpressure: none; this is a free-running control block with no flow-controlled interfaces.
module pll_lock_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int CE_DIV      = 5,
    parameter int LOSS_FILTER = 4,
    localparam int PW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pll_locked,
    output logic          sys_reset_n,
    output logic          ready,
    output logic          ce,
    output logic [PW-1:0] ce_phase,
    output logic [7:0]    lock_lost_count
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int FW = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [FW-1:0] LOSS_LAST  = FW'(LOSS_FILTER - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CE_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                lk;
    logic [HW-1:0]       hold_q, hold_d;
    logic [FW-1:0]       filt_q, filt_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [7:0]          lost_q, lost_d;

    // Lock synchroniser: the only consumer of the raw pll_locked input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    // State, counters and divider phase register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            filt_q  <= '0;
            phase_q <= '0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            filt_q  <= filt_d;
            phase_q <= phase_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state logic; counters default to 0 so every exit path clears them on the same edge.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        filt_d  = '0;
        phase_d = '0;
        lost_d  = lost_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Any low sample during the hold restarts sequencing without counting a loss.
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RUN: begin
                if (!lk) begin
                    if (filt_q == LOSS_LAST) begin
                        state_d = WAIT_LOCK;
                        if (lost_q != 8'hFF) begin
                            lost_d = lost_q + 8'd1;
                        end
                    end else begin
                        filt_d = filt_q + FW'(1);
                    end
                end
                // Phase only advances while staying in RUN; an exit forces it back to 0.
                if (state_d == RUN) begin
                    phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign ready           = (state_q == RUN);
    assign sys_reset_n     = (state_q == RUN);
    assign ce              = (state_q == RUN) && (phase_q == PHASE_LAST);
    assign ce_phase        = phase_q;
    assign lock_lost_count = lost_q;

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Consumes the PLL `locked` indication in the 88.671875 MHz system clock domain.
- Synchronises it and holds the core in reset until lock has been stable for a programmable period.
- Generates a 17.734375 MHz clock enable (divide-by-5) for logic running single-clock from the fast clock.
- Detects and counts loss-of-lock events during operation, and re-sequences the reset when lock is lost.

Parameters:
- SYNC_STAGES, 2, number of flops in the pll_locked synchroniser; legal values 2..4.
- HOLD_CYCLES, 1024, cycles of stable synchronised lock required before reset release; legal values >= 1.
- CE_DIV, 5, clock-enable divide ratio; legal values >= 2.
- LOSS_FILTER, 4, consecutive synchronised-low cycles in RUN that declare loss of lock; legal values >= 1.

Ports:
- clk, input, 1, system clock (PLL fast output, 88.671875 MHz).
- rst_n, input, 1, synchronous active-low reset.
- pll_locked, input, 1, PLL lock flag; asynchronous to clk.
- sys_reset_n, output, 1, active-low core reset; low while not in RUN.
- ready, output, 1, high while in RUN.
- ce, output, 1, single-cycle clock-enable pulse, once every CE_DIV cycles while in RUN.
- ce_phase, output, clog2(CE_DIV), divider phase, 0..CE_DIV-1.
- lock_lost_count, output, 8, saturating count of RUN-to-WAIT_LOCK lock-loss events.

Behaviour:
Reset:
- rst_n is sampled only on rising clk.
- While rst_n is low, every flop is cleared: synchroniser chain, hold counter, filter counter, divider phase and lock_lost_count all go to 0; state goes to WAIT_LOCK.
- Output values in reset: sys_reset_n=0, ready=0, ce=0, ce_phase=0, lock_lost_count=0.
- Reset asserted mid-operation (any state) takes effect at the next edge. lock_lost_count is cleared; the reset is not counted as a loss event.

Synchroniser:
- pll_locked passes through SYNC_STAGES flops. `lk` denotes the last stage.
- No other logic samples pll_locked directly.

States:
- WAIT_LOCK:
  - Hold counter and filter counter are held at 0.
  - lk=1 -> HOLD.
- HOLD:
  - The hold counter increments every cycle.
  - lk=0 in any HOLD cycle -> WAIT_LOCK immediately. There is no filter and the event is not counted.
  - Counter = HOLD_CYCLES-1 with lk=1 -> RUN. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- RUN:
  - The filter counter increments while lk=0 and clears to 0 while lk=1.
  - lk=0 with filter counter = LOSS_FILTER-1 -> WAIT_LOCK, and lock_lost_count increments (saturates at 255, no wrap).
  - Low runs of lk shorter than LOSS_FILTER cycles are ignored.

Latency:
- From pll_locked rising at edge 0 with constant lock, state=HOLD after edge SYNC_STAGES+1.
- ready=1 and sys_reset_n=1 after edge SYNC_STAGES+1+HOLD_CYCLES.
- From lk falling in RUN, ready drops after exactly LOSS_FILTER edges.

Outputs:
- sys_reset_n = (state==RUN).
- ready = (state==RUN).
- Both are decoded from the state register only; no combinational path from pll_locked or rst_n.

Divider:
- ce_phase is held at 0 outside RUN.
- In RUN, ce_phase increments by 1 each cycle and wraps from CE_DIV-1 to 0.
- ce = (state==RUN) && (ce_phase==CE_DIV-1).
- The first RUN cycle has ce_phase=0, so the first ce occurs in the CE_DIV-th RUN cycle and then every CE_DIV cycles.
- On exit from RUN, ce drops and ce_phase returns to 0 on the same edge. A partial divide period produces no ce.

Simultaneous events:
- rst_n low wins over everything.
- RUN exit on the same edge that ce_phase would wrap: state=WAIT_LOCK and ce_phase=0.
- lock_lost_count at 255 plus a new loss: value stays 255 and the state transition still occurs.

Test Plan:
- Power-up: set HOLD_CYCLES=16, SYNC_STAGES=2; hold rst_n=0 for 3 cycles, then release with pll_locked=0 -> sys_reset_n=0, ready=0, ce=0, lock_lost_count=0 for 100 cycles.
- Lock acquire: raise pll_locked at edge 0 -> HOLD entered after edge 3; ready and sys_reset_n rise after edge 19. Then ce pulses at RUN cycles 4, 9, 14 (CE_DIV=5), and ce_phase follows 0,1,2,3,4,0.
- Lock bounce in HOLD: drop pll_locked for 1 cycle at HOLD cycle 10 -> back to WAIT_LOCK; the hold restarts from 0 on re-lock; lock_lost_count stays 0.
- Glitch filter in RUN (LOSS_FILTER=4): a 3-cycle low on pll_locked -> ready stays 1 and count stays 0. A 4-cycle low -> ready=0 exactly 4 edges after lk falls, ce stops, ce_phase=0, lock_lost_count=1.
- Saturation: force 260 loss/re-lock cycles -> lock_lost_count reads 255 and each loss still drops ready.
- Reset mid-RUN: assert rst_n=0 for 1 cycle with pll_locked=1 -> all outputs cleared at that edge and lock_lost_count=0. The full SYNC_STAGES+1+HOLD_CYCLES sequence (19 edges) repeats before ready=1.
